// File: rtl/decode_stage_if.sv
// Decode-stage bus: instruction handshake, register writeback and decoded ALU bundle.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic        alu_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr;
  logic        illegal;

  modport master (
    output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_imm, funct3, funct7, op_a, op_b, rd_addr, illegal
  );

  modport slave (
    input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_imm, funct3, funct7, op_a, op_b, rd_addr, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I OP/OP-IMM decode stage: 32x32 register file with writeback forwarding
// and a single registered output bundle behind a valid/ready handshake.
module decode_stage (
  input  logic         clk,
  input  logic         rst,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic        alu_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        illegal;
  } bundle_t;

  logic [31:0] regs_q [32];
  bundle_t     bundle_q, bundle_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic        legal;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];

  // in_ready looks at the current out_valid, so it stays meaningful during rst.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand read with same-cycle writeback bypass; x0 is hard-wired to zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) begin
      rs1_val = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : regs_q[rs1];
    end
    if (rs2 != 5'd0) begin
      rs2_val = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : regs_q[rs2];
    end
  end

  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OPC_OP:     legal = (f7 == 7'h00) ||
                          (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OPC_OP_IMM: legal = !((f3 == 3'd1 && f7 != 7'h00) ||
                            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
      default:    legal = 1'b0;
    endcase
  end

  // Illegal encodings emit an all-zero bundle with only the illegal flag set.
  always_comb begin
    bundle_d = '0;
    if (!legal) begin
      bundle_d.illegal = 1'b1;
    end else begin
      bundle_d.alu_imm = (opcode == OPC_OP_IMM);
      bundle_d.funct3  = f3;
      bundle_d.funct7  = (opcode == OPC_OP_IMM) ? 7'h00 : f7;
      bundle_d.op_a    = rs1_val;
      bundle_d.op_b    = (opcode == OPC_OP_IMM) ?
                         {{20{bus.instr[31]}}, bus.instr[31:20]} : rs2_val;
      bundle_d.rd_addr = bus.instr[11:7];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        bundle_q <= bundle_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the register file is explicitly cleared on reset because software relies on
    // zeroed registers afterwards; this rules out mapping it onto a resetless RAM.
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_imm   = bundle_q.alu_imm;
  assign bus.funct3    = bundle_q.funct3;
  assign bus.funct7    = bundle_q.funct7;
  assign bus.op_a      = bundle_q.op_a;
  assign bus.op_b      = bundle_q.op_b;
  assign bus.rd_addr   = bundle_q.rd_addr;
  assign bus.illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: handshake, forwarding, legality and reset.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_bundle(input string tag, input logic valid, input logic imm,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic ill);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(valid));
    check({tag, ".alu_imm"},   32'(bus.alu_imm),   32'(imm));
    check({tag, ".funct3"},    32'(bus.funct3),    32'(f3));
    check({tag, ".funct7"},    32'(bus.funct7),    32'(f7));
    check({tag, ".op_a"},      bus.op_a,           a);
    check({tag, ".op_b"},      bus.op_b,           b);
    check({tag, ".rd_addr"},   32'(bus.rd_addr),   32'(rd));
    check({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    step();
    bus.wb_en   = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic        imm;
    logic [31:0] op_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    settle();
    check_bundle("reset", 1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);

    // addi x2,x1,-3 with x1=5
    wb(5'd1, 32'd5);
    bus.in_valid  = 1'b1;
    bus.instr     = 32'hFFD08113;
    bus.out_ready = 1'b1;
    settle();
    check("addi.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check_bundle("addi", 1'b1, 1'b1, 3'd0, 7'd0, 32'd5, 32'hFFFFFFFD, 5'd2, 1'b0);
    step();
    check("release.out_valid", 32'(bus.out_valid), 32'd0);

    // Forwarding: x1=7 written in the accept cycle
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 5'd1;
    bus.wb_data  = 32'd7;
    bus.in_valid = 1'b1;
    bus.instr    = 32'hFFD08113;
    step();
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b0;
    check("fwd.op_a", bus.op_a, 32'd7);
    check("fwd.out_valid", 32'(bus.out_valid), 32'd1);
    step();

    // sub x3,x1,x2 with x1=9, x2=4
    wb(5'd1, 32'd9);
    wb(5'd2, 32'd4);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h402081B3;
    step();
    check_bundle("sub", 1'b1, 1'b0, 3'd0, 7'h20, 32'd9, 32'd4, 5'd3, 1'b0);

    // Hold for 3 cycles with a pending instr; a writeback must not disturb the held bundle
    bus.out_ready = 1'b0;
    bus.instr     = 32'hFFD08113;
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd1;
    bus.wb_data   = 32'd100;
    settle();
    check("hold.in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wb_en = 1'b0;
      check_bundle($sformatf("hold%0d", i), 1'b1, 1'b0, 3'd0, 7'h20, 32'd9, 32'd4, 5'd3, 1'b0);
      check($sformatf("hold%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    settle();
    check("unhold.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_bundle("after_hold", 1'b1, 1'b1, 3'd0, 7'd0, 32'd100, 32'hFFFFFFFD, 5'd2, 1'b0);

    // JAL is illegal; bundle replaced back-to-back with no bubble
    bus.instr = 32'h0000006F;
    step();
    check_bundle("jal", 1'b1, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b1);

    // x0 writes are ignored, including same-cycle forwarding
    bus.in_valid = 1'b0;
    wb(5'd0, 32'd9);
    bus.in_valid = 1'b1;
    bus.instr    = 32'h00000113;
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'd9;
    step();
    bus.wb_en = 1'b0;
    check_bundle("x0", 1'b1, 1'b1, 3'd0, 7'd0, 32'd0, 32'd0, 5'd2, 1'b0);

    // Legality table, streamed back-to-back
    vecs[0] = '{32'h40101093, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{32'h40105093, 1'b0, 1'b1, 32'h00000401};
    vecs[2] = '{32'h402091B3, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h022081B3, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{32'h4020D1B3, 1'b0, 1'b0, 32'd4};
    vecs[5] = '{32'h80105093, 1'b1, 1'b0, 32'h0};
    foreach (vecs[i]) begin
      bus.instr = vecs[i].instr;
      step();
      check($sformatf("vec%0d.illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
      check($sformatf("vec%0d.alu_imm", i), 32'(bus.alu_imm), 32'(vecs[i].imm));
      check($sformatf("vec%0d.op_b", i),    bus.op_b,         vecs[i].op_b);
    end

    // Reset while a bundle is pending, with accept and writeback also requested
    bus.out_ready = 1'b0;
    bus.instr     = 32'h002081B3;
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd5;
    bus.wb_data   = 32'd55;
    rst           = 1'b1;
    settle();
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst       = 1'b0;
    bus.wb_en = 1'b0;
    check_bundle("rst", 1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.instr = 32'h0052_81B3; // add x3,x5,x5
    step();
    bus.in_valid = 1'b0;
    check_bundle("post_rst_x5", 1'b1, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd3, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.instr    = 32'h002081B3;
    step();
    bus.in_valid = 1'b0;
    check_bundle("post_rst_x1", 1'b1, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  instr is valid this cycle.
REQ-005 in_ready  output  1  block accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 wb_en  input  1  register-file write enable.
REQ-008 wb_addr  input  5  write register index.
REQ-009 wb_data  input  32  write data.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream ALU stage takes bundle.
REQ-012 alu_imm  output  1  1 = immediate-form ALU op (OP-IMM), 0 = register form (OP).
REQ-013 funct3  output  3  ALU funct3.
REQ-014 funct7  output  7  ALU funct7; 0 for immediate form.
REQ-015 op_a  output  32  first ALU operand (rs1 value).
REQ-016 op_b  output  32  second ALU operand (rs2 value or sign-extended imm).
REQ-017 rd_addr  output  5  destination register index.
REQ-018 illegal  output  1  instruction not a legal OP/OP-IMM encoding.

Function
REQ-019 Storage SHALL be a 32x32 register file plus one output bundle register.
REQ-020 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-021 Accept SHALL occur when in_valid && in_ready; the bundle appears on outputs with out_valid=1 on the next cycle (latency 1).
REQ-022 Bundle SHALL be released when out_valid && out_ready; out_valid drops next cycle unless a new accept happens the same cycle.
REQ-023 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-024 Writeback: on wb_en at a clock edge, regfile[wb_addr] <= wb_data, except wb_addr=0 is ignored; x0 reads SHALL always return 0.
REQ-025 Operand read SHALL occur in the accept cycle; if wb_en && wb_addr==src && src!=0 in that cycle, wb_data SHALL be forwarded.
REQ-026 Captured operands SHALL NOT be updated by later writebacks while held.
REQ-027 OP (opcode 0110011): alu_imm=0, funct3=instr[14:12], funct7=instr[31:25], op_a=x[rs1], op_b=x[rs2], rd_addr=instr[11:7].
REQ-028 OP-IMM (opcode 0010011): alu_imm=1, funct7=0, op_a=x[rs1], op_b={{20{instr[31]}},instr[31:20]}, rd_addr=instr[11:7].
REQ-029 OP is illegal unless funct7=0x00, or funct7=0x20 with funct3 in {0,5}.
REQ-030 OP-IMM is illegal if funct3=1 and instr[31:25]!=0, or funct3=5 and instr[31:25] not in {0x00,0x20}.
REQ-031 Any other opcode is illegal.
REQ-032 An illegal instruction SHALL still be accepted and emitted with illegal=1, and alu_imm, funct3, funct7, op_a, op_b, rd_addr all 0.
REQ-033 Simultaneous release and accept SHALL replace the bundle with no bubble cycle.

Reset
REQ-034 On rst, out_valid, alu_imm, funct3, funct7, op_a, op_b, rd_addr, illegal and all 32 registers SHALL be 0 next cycle.
REQ-035 Reset SHALL take priority over accept, release and writeback in the same cycle; a pending bundle is discarded.
REQ-036 During rst, in_ready SHALL follow REQ-020 using the current (pre-reset) out_valid.

Verification
REQ-037 wb x1=5; then accept 0xFFD08113 (addi x2,x1,-3), out_ready=1 -> next cycle out_valid=1, alu_imm=1, funct3=0, funct7=0, op_a=5, op_b=0xFFFFFFFD, rd_addr=2, illegal=0.
REQ-038 wb x1=7 with wb_en in the same cycle 0xFFD08113 is accepted -> op_a=7 (forwarding).
REQ-039 x1=9, x2=4; accept 0x402081B3 (sub x3,x1,x2) -> alu_imm=0, funct3=0, funct7=0x20, op_a=9, op_b=4, rd_addr=3.
REQ-040 out_ready=0 for 3 cycles with bundle held and in_valid=1 -> in_ready=0, outputs unchanged, no second accept; out_ready=1 -> next instr accepted that cycle.
REQ-041 Accept 0x0000006F (JAL) -> illegal=1, other bundle fields 0; wb x0=9 then read x0 -> op_a=0.
REQ-042 rst asserted while out_valid=1 -> out_valid=0 and regfile cleared next cycle; subsequent read of x1 yields 0.
